watch_set_ctrl: RTL
===================

# watch_set_ctrl

Time-setting sequencer for the watch datapath. While watch-set mode is active, it captures the running time into shadow registers and lets the user select a field (hour, min, sec) and step it up or down with wrap-around. Each change is pushed to the watch counters with a one-cycle load strobe. It sits between the control unit's muxed mode/button outputs and the watch counter block.

## Interface
- CLK_HZ, 100_000_000, clock frequency used to derive repeat timing
- REPEAT_DELAY_MS, 500, hold time before auto-repeat starts
- REPEAT_RATE_MS, 100, auto-repeat step period
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- i_set_mode  input  1  watch-set mode level (muxed sw/UART watch_set)
- i_next  input  1  one-cycle pulse: select next field
- i_prev  input  1  one-cycle pulse: select previous field
- i_up  input  1  debounced level: increment held
- i_down  input  1  debounced level: decrement held
- i_cur_hour  input  5  running hour, 0..23
- i_cur_min  input  6  running minute, 0..59
- i_cur_sec  input  6  running second, 0..59
- o_set_hour  output  5  shadow hour
- o_set_min  output  6  shadow minute
- o_set_sec  output  6  shadow second
- o_load  output  1  one-cycle strobe: watch loads o_set_*
- o_field  output  2  00 none, 01 hour, 10 min, 11 sec (display blink select)
- o_setting  output  1  high in any non-IDLE state

## Operation
- States: IDLE, HOUR, MIN, SEC. Reset and any state with i_set_mode=0 -> IDLE.
- IDLE, i_set_mode rising edge -> HOUR. The same edge copies i_cur_* into the shadow registers. No o_load is issued.
- i_next: HOUR->MIN->SEC->HOUR. i_prev: the reverse. Both in one cycle -> no move.
- Step events are rising edges of i_up/i_down, detected internally from the previous-cycle sample, plus repeat ticks (see Configuration).
- Up step: the active field increments. Wraps 23->0 for hour and 59->0 for min/sec. Down step wraps 0->23 and 0->59.
- Up and down step in the same cycle -> no step, no load.
- A step and i_next/i_prev in the same cycle -> the step applies to the field active in that cycle, then the move takes effect.
- Every step produces exactly one o_load.
- Only the addressed shadow field changes. There is no carry between fields.
- Leaving set mode (i_set_mode falling) -> IDLE next cycle. Shadows hold their values. No extra load.
- Steps and moves are ignored in IDLE.
- o_field = 00 in IDLE, otherwise it encodes the state. o_setting = (state != IDLE).

## Timing
- Reset values: state IDLE, o_set_* = 0, o_load = 0, o_field = 00, o_setting = 0. Edge-detect samples and repeat counter = 0.
- Capture: i_set_mode rises in cycle N -> state HOUR and shadows valid in N+1.
- Step: an edge seen in cycle N (i_up high in N, low in N-1) -> o_set_* updated and o_load = 1 in N+1, o_load = 0 in N+2.
- o_set_* are registered and hold their value between loads.
- Reset asserted mid-setting -> immediate IDLE, no load. Outputs go to their reset values asynchronously.
- Moves take effect in the next cycle. o_field follows the state with no added latency.

## Configuration
- AUTO_REPEAT_EN defined:
  - Holding i_up or i_down continuously for REPEAT_DELAY_MS*CLK_HZ/1000 cycles after the edge step generates a repeat step.
  - Further repeat steps follow every REPEAT_RATE_MS*CLK_HZ/1000 cycles while the key stays held.
  - Releasing the key, both keys high, a field move, or leaving set mode clears the repeat counter.
- AUTO_REPEAT_EN undefined: edge steps only. The repeat counter and its logic are not synthesized.

## Structure
- Package watch_set_pkg holds:
  - the state enum (IDLE=2'b00, HOUR=2'b01, MIN=2'b10, SEC=2'b11), which doubles as the o_field encoding
  - HOUR_MAX=23 and MINSEC_MAX=59
- One sub-module, key_repeat: per-key edge detect plus the delay/rate counter, emitting a one-cycle step pulse. It is instantiated twice (up, down). Under AUTO_REPEAT_EN undefined it reduces to a plain edge detector.

## Test plan
- Reset low with arbitrary inputs -> all outputs 0, o_field=00. After release with i_set_mode=0, pulses on i_up/i_next -> no o_load.
- i_cur = 12:34:56, raise i_set_mode -> next cycle o_field=01 and o_set = 12:34:56. No o_load.
- In HOUR with shadow 23, pulse i_up -> o_set_hour=0 and a single-cycle o_load. Then i_next and i_down twice with min=0 -> min goes 59 then 58, hour stays 0.
- i_up and i_down rising in the same cycle -> no load, shadows unchanged. i_next with i_prev -> o_field unchanged.
- AUTO_REPEAT_EN with CLK_HZ=1000, DELAY=5 ms, RATE=2 ms, holding i_up for 12 cycles from sec=58:
  - loads occur at cycles 1, 6, 8, 10, 12
  - sec goes 59, 0, 1, 2, 3
- Reset asserted one cycle after a step edge -> no o_load, state IDLE.

Source files
------------

// File: rtl/watch_set_pkg.sv
// watch_set_pkg: shared state/field encoding, field limits and wrap-around stepping for watch_set_ctrl
package watch_set_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, HOUR = 2'b01, MIN = 2'b10, SEC = 2'b11} state_t;
  localparam logic [5:0] HOUR_MAX = 6'd23;
  localparam logic [5:0] MINSEC_MAX = 6'd59;
  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] max, input logic up);
    return up ? ((v == max) ? 6'd0 : v + 6'd1) : ((v == 6'd0) ? max : v - 6'd1);
  endfunction
endpackage

// File: rtl/watch_set_ctrl_key_repeat.sv
// key_repeat: rising-edge step pulse per key, plus delay/rate auto-repeat when AUTO_REPEAT_EN is defined
module key_repeat
`ifdef AUTO_REPEAT_EN
#(
  parameter int DELAY_CYC = 2,
  parameter int RATE_CYC = 1
)
`endif
(
  input  logic clk,
  input  logic reset,
`ifdef AUTO_REPEAT_EN
  input  logic clr,
`endif
  input  logic key,
  output logic step
);
  logic key_q;
  // previous-cycle key sample for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) key_q <= 1'b0;
    else key_q <= key;
  end
`ifdef AUTO_REPEAT_EN
  localparam int W = $clog2(DELAY_CYC + 1);
  logic [W-1:0] cnt;
  logic rep;
  assign rep = key && (cnt == W'(DELAY_CYC));
  // hold-time counter; after the first repeat it reloads so the next one lands RATE_CYC later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else cnt <= (key && !clr) ? (rep ? W'(DELAY_CYC - RATE_CYC + 1) : cnt + W'(1)) : '0;
  end
  assign step = (key & ~key_q) | rep;
`else
  assign step = key & ~key_q;
`endif
endmodule

// File: rtl/watch_set_ctrl.sv
// watch_set_ctrl: watch time-setting sequencer (field select, wrap-around step, load strobe); optional AUTO_REPEAT_EN
module watch_set_ctrl #(
  parameter int CLK_HZ = 100_000_000,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_RATE_MS = 100
)(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_set_mode,
  input  logic       i_next,
  input  logic       i_prev,
  input  logic       i_up,
  input  logic       i_down,
  input  logic [4:0] i_cur_hour,
  input  logic [5:0] i_cur_min,
  input  logic [5:0] i_cur_sec,
  output logic [4:0] o_set_hour,
  output logic [5:0] o_set_min,
  output logic [5:0] o_set_sec,
  output logic       o_load,
  output logic [1:0] o_field,
  output logic       o_setting
);
  import watch_set_pkg::*;
  state_t state, nxt_field, prv_field;
  logic sm_q, up_step, dn_step, inc, dec;
`ifdef AUTO_REPEAT_EN
  localparam int DELAY_CYC = REPEAT_DELAY_MS * (CLK_HZ / 1000);
  localparam int RATE_CYC = REPEAT_RATE_MS * (CLK_HZ / 1000);
  logic clr;
  assign clr = i_next | i_prev | ~i_set_mode | (i_up & i_down);
  key_repeat #(.DELAY_CYC(DELAY_CYC), .RATE_CYC(RATE_CYC)) u_up (.clk(clk), .reset(reset), .clr(clr), .key(i_up), .step(up_step));
  key_repeat #(.DELAY_CYC(DELAY_CYC), .RATE_CYC(RATE_CYC)) u_dn (.clk(clk), .reset(reset), .clr(clr), .key(i_down), .step(dn_step));
`else
  key_repeat u_up (.clk(clk), .reset(reset), .key(i_up), .step(up_step));
  key_repeat u_dn (.clk(clk), .reset(reset), .key(i_down), .step(dn_step));
`endif
  assign inc = up_step & ~dn_step;
  assign dec = dn_step & ~up_step;
  assign nxt_field = (state == SEC) ? HOUR : state_t'(state + 2'd1);
  assign prv_field = (state == HOUR) ? SEC : state_t'(state - 2'd1);
  assign o_field = state;
  assign o_setting = (state != IDLE);
  // field-select FSM with shadow capture on entry and one load strobe per step
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sm_q <= 1'b0;
      o_set_hour <= '0;
      o_set_min <= '0;
      o_set_sec <= '0;
      o_load <= 1'b0;
    end else begin
      sm_q <= i_set_mode;
      o_load <= i_set_mode && (state != IDLE) && (inc || dec);
      if (!i_set_mode) state <= IDLE;
      else if (state == IDLE) begin
        if (!sm_q) begin
          state <= HOUR;
          o_set_hour <= i_cur_hour;
          o_set_min <= i_cur_min;
          o_set_sec <= i_cur_sec;
        end
      end else begin
        if (inc || dec) begin
          if (state == HOUR) o_set_hour <= 5'(wrap_step({1'b0, o_set_hour}, HOUR_MAX, inc));
          if (state == MIN) o_set_min <= wrap_step(o_set_min, MINSEC_MAX, inc);
          if (state == SEC) o_set_sec <= wrap_step(o_set_sec, MINSEC_MAX, inc);
        end
        if (i_next && !i_prev) state <= nxt_field;
        else if (i_prev && !i_next) state <= prv_field;
      end
    end
  end
endmodule
